// File: rtl/fp_addsub_seq.sv
// Multi-cycle parametrised floating-point add/subtract unit with valid/ready handshakes.
// Build macro FPU_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise results truncate.
module fp_addsub_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);
  localparam int unsigned DW  = MAN_W + 5;
  localparam int unsigned EW1 = EXP_W + 1;
  localparam logic [EW1-1:0] EXP_INF = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [DW-1:0]    big_q, big_d, small_q, small_d, mag_q, mag_d;
  logic             sign_big_q, sign_big_d, sign_small_q, sign_small_d, sign_q, sign_d;
  logic [EW1-1:0]   exp_q, exp_d;
  logic             special_q, special_d;
  logic [MAN_W-1:0] nan_frac_q, nan_frac_d;
  logic             unf_q, unf_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [W-1:0]     result_q, result_d;
  logic [2:0]       flags_q, flags_d;

  // Alignment: significand layout is {carry, hidden, fraction, G, R, S}
  logic [EXP_W-1:0] exp_a, exp_b, exp_diff;
  logic [DW-1:0]    sig_a, sig_b, sig_sm, sh_mask, sig_sh;
  logic             a_big;

  assign exp_a    = a_q[W-2:MAN_W];
  assign exp_b    = b_q[W-2:MAN_W];
  assign sig_a    = (exp_a == '0) ? '0 : {2'b01, a_q[MAN_W-1:0], 3'b000};
  assign sig_b    = (exp_b == '0) ? '0 : {2'b01, b_q[MAN_W-1:0], 3'b000};
  assign a_big    = exp_a > exp_b;
  assign exp_diff = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
  assign sig_sm   = a_big ? sig_b : sig_a;
  assign sh_mask  = ~({DW{1'b1}} << exp_diff);
  assign sig_sh   = (32'(exp_diff) >= MAN_W + 3) ? DW'(|sig_sm)
                  : ((sig_sm >> exp_diff) | DW'(|(sig_sm & sh_mask)));

  // Rounding: fraction wraps to zero exactly when the significand carries out
  logic             rnd_inc, rnd_carry, grs_any, ovf;
  logic [EW1-1:0]   exp_r;
  logic [MAN_W-1:0] frac_r;

  assign grs_any = |mag_q[2:0];
`ifdef FPU_ROUND_NEAREST_EN
  assign rnd_inc = mag_q[2] & (mag_q[1] | mag_q[0] | mag_q[3]);
`else
  assign rnd_inc = 1'b0;
`endif
  assign rnd_carry = rnd_inc & (&mag_q[DW-2:3]);
  assign frac_r    = mag_q[MAN_W+2:3] + MAN_W'(rnd_inc);
  assign exp_r     = rnd_carry ? (exp_q + EW1'(1)) : exp_q;
  assign ovf       = exp_r >= EXP_INF;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    big_d        = big_q;
    small_d      = small_q;
    mag_d        = mag_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    sign_d       = sign_q;
    exp_d        = exp_q;
    special_d    = special_q;
    nan_frac_d   = nan_frac_q;
    unf_d        = unf_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    flags_d      = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = data_a;
          b_d        = {data_b[W-1] ^ op, data_b[W-2:0]};
          unf_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = S_ALIGN;
        end
      end
      S_ALIGN: begin
        big_d        = a_big ? sig_a : sig_b;
        small_d      = sig_sh;
        sign_big_d   = a_big ? a_q[W-1] : b_q[W-1];
        sign_small_d = a_big ? b_q[W-1] : a_q[W-1];
        exp_d        = EW1'(a_big ? exp_a : exp_b);
        special_d    = (&exp_a) | (&exp_b);
        nan_frac_d   = a_q[MAN_W-1:0] | b_q[MAN_W-1:0];
        state_d      = S_ADD;
      end
      S_ADD: begin
        if (sign_big_q == sign_small_q) begin
          mag_d  = big_q + small_q;
          sign_d = sign_big_q;
        end else if (big_q >= small_q) begin
          mag_d  = big_q - small_q;
          sign_d = sign_big_q;
        end else begin
          mag_d  = small_q - big_q;
          sign_d = sign_small_q;
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (mag_q[DW-1]) begin
          mag_d   = {1'b0, mag_q[DW-1:2], mag_q[1] | mag_q[0]};
          exp_d   = exp_q + EW1'(1);
          state_d = S_ROUND;
        end else if (mag_q == '0) begin
          sign_d  = 1'b0;
          exp_d   = '0;
          state_d = S_ROUND;
        end else if (!mag_q[DW-2]) begin
          // A left shift that would bring the exponent to zero flushes instead
          if (exp_q <= EW1'(1)) begin
            mag_d   = '0;
            exp_d   = '0;
            unf_d   = 1'b1;
            state_d = S_ROUND;
          end else begin
            mag_d = mag_q << 1;
            exp_d = exp_q - EW1'(1);
          end
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (special_q) begin
          result_d = {sign_big_q, {EXP_W{1'b1}}, nan_frac_q};
          flags_d  = 3'b000;
        end else if (ovf) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d  = {1'b1, unf_q, 1'b1};
        end else begin
          result_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
          flags_d  = {1'b0, unf_q, grs_any};
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      big_q        <= '0;
      small_q      <= '0;
      mag_q        <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      special_q    <= 1'b0;
      nan_frac_q   <= '0;
      unf_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      big_q        <= big_d;
      small_q      <= small_d;
      mag_q        <= mag_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      sign_q       <= sign_d;
      exp_q        <= exp_d;
      special_q    <= special_d;
      nan_frac_q   <= nan_frac_d;
      unf_q        <= unf_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: directed single-precision vectors with hand-computed results.
`timescale 1ns/1ps
module tb_fp_addsub_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op = 1'b0;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [2:0]  flags;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb_q[$];

`ifdef FPU_ROUND_NEAREST_EN
  localparam logic [31:0] RND_RES = 32'h3F800001;
`else
  localparam logic [31:0] RND_RES = 32'h3F800000;
`endif

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .data_a(data_a), .data_b(data_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
    end
  endtask

  // Drive one operation; optionally push its expected response to the scoreboard
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic o,
                       input logic [31:0] res, input logic [2:0] flg, input int lat, input bit push);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_in_ready", 32'(in_ready), 32'd1);
    data_a   = a;
    data_b   = b;
    op       = o;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      e.res = res;
      e.flg = flg;
      e.lat = lat;
      e.acc = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 100), 32'd1);
  endtask

  // Monitor: one pop per rising out_valid
  initial begin : monitor
    exp_t e;
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", result, 32'hXXXXXXXX);
        end else begin
          e = sb_q.pop_front();
          chk("result", result, e.res);
          chk("flags", 32'(flags), 32'(e.flg));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;

    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 4, 1'b1);
    issue(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 3'b000, 5, 1'b1);
    issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 4, 1'b1);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b101, 4, 1'b1);
    issue(32'h3F800000, 32'h33C00000, 1'b0, RND_RES,      3'b001, 4, 1'b1);
    issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 4, 1'b1);
    issue(32'h3F800000, 32'h32800000, 1'b0, 32'h3F800000, 3'b001, 4, 1'b1);
    issue(32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 3'b000, 5, 1'b1);
    issue(32'h00000000, 32'h3FC00000, 1'b1, 32'hBFC00000, 3'b000, 4, 1'b1);
    issue(32'h80000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000, 4, 1'b1);
    issue(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010, 4, 1'b1);
    issue(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, 4, 1'b1);
    issue(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000, 4, 1'b1);
    drain();

    // Back-pressure: result held, in_ready low, stray in_valid ignored
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 4, 1'b1);
    data_a   = 32'h41200000;
    data_b   = 32'h40A00000;
    op       = 1'b1;
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_wait", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_result", result, 32'h40400000);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("ready_return", 32'(in_ready), 32'd1);

    // Reset pulse during NORM aborts the operation
    issue(32'h3FC00000, 32'h3F800000, 1'b1, 32'h0, 3'b000, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_output", 32'(out_valid), 32'd0);
    end
    issue(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 3'b000, 5, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
